q_max_reader: RTL and testbench
===============================

# q_max_reader

Reads all action Q-values of one state from the Q-table RAM and returns the maximum Q-value and its action index (argmax). It sits on the read side of the Q-table. It supplies max Q(s',a') for the Q-update target and the greedy action for the policy. It is the reader counterpart to the delayed state/action/reward write path. Operation is a single-shot request/done transaction, pipelined at one RAM read per cycle.

## Interface
- STATE_W, default 6: state index width.
- ACTION_W, default 2: action index width.
- NUM_ACTIONS, default 4: actions per state; must be ≤ 2**ACTION_W and ≥ 1.
- Q_W, default 16: Q-value width, signed two's complement.

- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- state_in  input  STATE_W  state to scan; latched on accepted start.
- busy  output  1  high from the cycle after an accepted start through the done cycle.
- done  output  1  one-cycle pulse; results valid.
- max_q  output  Q_W  largest Q-value; held until the next done.
- max_action  output  ACTION_W  action index of max_q; held until the next done.
- ram_rd_en  output  1  RAM read strobe.
- ram_rd_addr  output  STATE_W+ACTION_W  read address {state, action}.
- ram_rd_data  input  Q_W  RAM data; valid exactly one cycle after ram_rd_en (registered RAM).

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - busy=0.
  - On start=1, latch state_in, clear the action counter, and go to ISSUE.
- ISSUE:
  - ram_rd_en=1 and ram_rd_addr={latched_state, cnt}.
  - cnt increments each cycle.
  - After issuing cnt=NUM_ACTIONS-1, go to DRAIN.
- DRAIN: one cycle that waits for the last read data, then goes to DONE.
- DONE:
  - done=1 for one cycle.
  - Register max_q and max_action from the accumulator.
  - Return to IDLE.
- Accumulator:
  - A valid-tagged pipeline tracks the returning data and its action index; rd_en is delayed by one cycle together with the action index.
  - The first returned value (action 0) loads unconditionally.
  - Each later value replaces the accumulator only if strictly greater, using a signed comparison.
  - Ties keep the lower action index.
- start while busy: ignored, with no queueing.
- start in the same cycle as done: ignored, because the FSM is not in IDLE; a new start is accepted in the following cycle.
- ram_rd_en=0 and ram_rd_addr=0 outside ISSUE.
- Arithmetic: comparisons only, no overflow possible; full Q_W signed range supported, including 16'h8000.

## Timing
- Reset values:
  - FSM=IDLE, busy=0, done=0, max_q=0, max_action=0, ram_rd_en=0, ram_rd_addr=0.
  - Accumulator and counter cleared.
- Reset asserted mid-scan:
  - Aborts immediately (asynchronous).
  - No done pulse.
  - Outputs return to reset values.
- Start accepted at edge 0:
  - Reads are issued in cycles 1..NUM_ACTIONS.
  - Data is compared in cycles 2..NUM_ACTIONS+1.
  - done pulses in cycle NUM_ACTIONS+2; with the defaults, done is in cycle 6.
- Throughput: one scan per NUM_ACTIONS+3 cycles (includes the IDLE cycle).
- max_q and max_action change only in the done cycle and are stable otherwise.

## Structure
- Shared package q_pkg:
  - STATE_W, ACTION_W, Q_W, NUM_ACTIONS defaults.
  - The typedefs q_t (signed Q_W), state_t, action_t.
  - An address-compose function make_q_addr(state, action).
  - The same package is used by the delay/write-back path so that address packing matches.
- Sub-module q_argmax_acc:
  - Clocked running max/argmax register.
  - Inputs: clear, valid, data, index.
  - Keeps the FSM separate from the compare datapath.

## Test plan
- Basic max:
  - state 5, RAM row = {10, 300, -7, 42}.
  - Expected: done in cycle 6, max_q=300, max_action=1, addresses 0x14..0x17 in cycles 1..4.
- All negative with ties:
  - Row = {-5, -3, -3, 16'h8000}.
  - Expected: max_q=-3, max_action=1 (lowest index wins tie).
- Extremes:
  - Row = {16'h8000, 16'h8000, 16'h8000, 16'h7FFF}.
  - Expected: max_q=32767, max_action=3.
  - Then all-equal row {0, 0, 0, 0}: max_q=0, max_action=0.
- Start while busy:
  - Pulse start with state 1 at cycle 0.
  - Pulse start again with state 2 at cycles 3 and 6.
  - Expected: only state 1 is scanned, exactly one done; a start at cycle 7 is accepted.
- Reset mid-scan:
  - Assert rst in cycle 3.
  - Expected: no done; all outputs zero; a subsequent scan of state 63 reads addresses 0xFC..0xFF and produces correct results.
- Back-to-back:
  - Issue consecutive scans of states 0 and 1, with start asserted continuously.
  - Expected: done pulses 7 cycles apart; results held between pulses.

Source files
------------

// File: rtl/q_pkg.sv
// Shared Q-table definitions: default widths, value/index types and the {state, action} address packing.
// The reader and the delayed write-back path both use this package, so RAM addresses pack the same way.
package q_pkg;

  localparam int DEF_STATE_W     = 6;
  localparam int DEF_ACTION_W    = 2;
  localparam int DEF_NUM_ACTIONS = 4;
  localparam int DEF_Q_W         = 16;

  typedef logic signed [DEF_Q_W-1:0]              q_t;
  typedef logic [DEF_STATE_W-1:0]                 state_t;
  typedef logic [DEF_ACTION_W-1:0]                action_t;
  typedef logic [DEF_STATE_W+DEF_ACTION_W-1:0]    q_addr_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_DRAIN,
    RD_DONE
  } rd_fsm_t;

  function automatic q_addr_t make_q_addr(input state_t s, input action_t a);
    return {s, a};
  endfunction

endpackage

// File: rtl/q_argmax_acc.sv
// Running signed max/argmax register. It updates one cycle after a valid sample and never stalls.
// It has no backpressure. The first sample after clear loads unconditionally, and ties keep the earlier (lower) index.
module q_argmax_acc #(
  parameter int Q_W   = 16,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid,
  input  logic [Q_W-1:0]   data,
  input  logic [IDX_W-1:0] index,
  output logic [Q_W-1:0]   acc_q,
  output logic [IDX_W-1:0] acc_idx
);

  logic has_val;
  logic take;

  // Strictly-greater compare so that an equal later value never displaces the lower index.
  assign take = valid && (!has_val || ($signed(data) > $signed(acc_q)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      has_val <= 1'b0;
      acc_q   <= '0;
      acc_idx <= '0;
    end else if (clear) begin
      has_val <= 1'b0;
      acc_q   <= '0;
      acc_idx <= '0;
    end else if (take) begin
      has_val <= 1'b1;
      acc_q   <= data;
      acc_idx <= index;
    end
  end

endmodule

// File: rtl/q_max_reader.sv
// Scans every action Q-value of one state and returns max Q and argmax. done arrives NUM_ACTIONS+2 cycles after start.
// There is no backpressure. A start is taken only in IDLE, and any start while busy is dropped.
module q_max_reader
  import q_pkg::*;
#(
  parameter int STATE_W     = DEF_STATE_W,
  parameter int ACTION_W    = DEF_ACTION_W,
  parameter int NUM_ACTIONS = DEF_NUM_ACTIONS,
  parameter int Q_W         = DEF_Q_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [STATE_W-1:0]          state_in,
  output logic                        busy,
  output logic                        done,
  output logic [Q_W-1:0]              max_q,
  output logic [ACTION_W-1:0]         max_action,
  output logic                        ram_rd_en,
  output logic [STATE_W+ACTION_W-1:0] ram_rd_addr,
  input  logic [Q_W-1:0]              ram_rd_data
);

  localparam logic [ACTION_W-1:0] LAST_ACTION = ACTION_W'(NUM_ACTIONS - 1);

  rd_fsm_t                     fsm, fsm_nx;
  logic [STATE_W-1:0]          st_r;
  logic [ACTION_W-1:0]         cnt;
  logic                        rd_vld_d;
  logic [ACTION_W-1:0]         idx_d;
  logic [Q_W-1:0]              max_q_r;
  logic [ACTION_W-1:0]         max_act_r;
  logic [Q_W-1:0]              acc_q;
  logic [ACTION_W-1:0]         acc_idx;
  logic                        accept;
  logic                        issuing;
  logic [STATE_W+ACTION_W-1:0] rd_addr;

  assign accept  = (fsm == RD_IDLE) && start;
  assign issuing = (fsm == RD_ISSUE);

  always_comb begin
    fsm_nx = fsm;
    case (fsm)
      RD_IDLE:  if (start) fsm_nx = RD_ISSUE;
      RD_ISSUE: if (cnt == LAST_ACTION) fsm_nx = RD_DRAIN;
      RD_DRAIN: fsm_nx = RD_DONE;
      RD_DONE:  fsm_nx = RD_IDLE;
      default:  fsm_nx = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= RD_IDLE;
      st_r      <= '0;
      cnt       <= '0;
      rd_vld_d  <= 1'b0;
      idx_d     <= '0;
      max_q_r   <= '0;
      max_act_r <= '0;
    end else begin
      fsm <= fsm_nx;
      if (accept) begin
        st_r <= state_in;
        cnt  <= '0;
      end else if (issuing) begin
        cnt <= cnt + 1'b1;
      end
      // The read strobe and its action travel one cycle behind, matching the registered RAM latency.
      rd_vld_d <= issuing;
      idx_d    <= cnt;
      if (fsm == RD_DONE) begin
        max_q_r   <= acc_q;
        max_act_r <= acc_idx;
      end
    end
  end

  generate
    if (STATE_W == DEF_STATE_W && ACTION_W == DEF_ACTION_W) begin : g_pkg_addr
      assign rd_addr = make_q_addr(state_t'(st_r), action_t'(cnt));
    end else begin : g_local_addr
      assign rd_addr = {st_r, cnt};
    end
  endgenerate

  q_argmax_acc #(
    .Q_W   (Q_W),
    .IDX_W (ACTION_W)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .valid   (rd_vld_d),
    .data    (ram_rd_data),
    .index   (idx_d),
    .acc_q   (acc_q),
    .acc_idx (acc_idx)
  );

  assign busy        = (fsm != RD_IDLE);
  assign done        = (fsm == RD_DONE);
  assign ram_rd_en   = issuing;
  assign ram_rd_addr = issuing ? rd_addr : '0;
  // The accumulator is final throughout DONE, so results are presented with the pulse and then held.
  assign max_q       = done ? acc_q   : max_q_r;
  assign max_action  = done ? acc_idx : max_act_r;

endmodule

// File: tb/tb_q_max_reader.sv
// Self-checking bench for q_max_reader: registered RAM model, result/address scoreboards, table vectors and corner sequences.
module tb_q_max_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  state_in;
  logic        busy;
  logic        done;
  logic [15:0] max_q;
  logic [1:0]  max_action;
  logic        ram_rd_en;
  logic [7:0]  ram_rd_addr;
  logic [15:0] ram_rd_data;

  typedef struct packed {
    logic [15:0] q;
    logic [1:0]  a;
  } res_t;

  typedef struct {
    logic [5:0]  st;
    logic [15:0] r0, r1, r2, r3;
    logic [15:0] exp_q;
    logic [1:0]  exp_a;
  } vec_t;

  logic [15:0] mem [256];
  res_t        res_q[$];
  logic [7:0]  addr_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] prev_q;
  logic [1:0]  prev_a;

  always #5 clk = ~clk;

  q_max_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .state_in    (state_in),
    .busy        (busy),
    .done        (done),
    .max_q       (max_q),
    .max_action  (max_action),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  // Registered RAM: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_row(input logic [5:0] s, input logic [15:0] r0, r1, r2, r3);
    mem[{s, 2'd0}] = r0;
    mem[{s, 2'd1}] = r1;
    mem[{s, 2'd2}] = r2;
    mem[{s, 2'd3}] = r3;
  endtask

  // Reference: signed max, strictly-greater replacement, scanning from action 0.
  function automatic res_t ref_res(input logic [5:0] s);
    res_t r;
    r.q = mem[{s, 2'd0}];
    r.a = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if ($signed(mem[{s, 2'(i)}]) > $signed(r.q)) begin
        r.q = mem[{s, 2'(i)}];
        r.a = 2'(i);
      end
    end
    return r;
  endfunction

  task automatic expect_scan(input logic [5:0] s, input res_t r);
    res_q.push_back(r);
    for (int i = 0; i < 4; i++) addr_q.push_back({s, 2'(i)});
  endtask

  // Starts a scan and checks read window, busy and done latency in cycles counted from the accepting edge.
  task automatic run_scan(input logic [5:0] s, input logic [15:0] eq, input logic [1:0] ea);
    int found;
    found = 0;
    @(posedge clk); #1;
    start = 1'b1;
    state_in = s;
    expect_scan(s, '{q: eq, a: ea});
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k <= 6) begin
        chk("rd_en_window", ram_rd_en, (k >= 1 && k <= 4));
        chk("busy_window", busy, 1);
      end
      if (done) begin
        found = k;
        break;
      end
    end
    chk("done_cycle", found, 6);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done) begin
        cycles = k;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      prev_q = max_q;
      prev_a = max_action;
    end else begin
      if (ram_rd_en) begin
        if (addr_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rd_addr_unexpected: read of 0x%0h with none expected", ram_rd_addr);
        end else begin
          chk("rd_addr", ram_rd_addr, addr_q.pop_front());
        end
      end else begin
        chk("rd_addr_idle", ram_rd_addr, 0);
      end
      if (done) begin
        if (res_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done_unexpected: done with max_q=0x%0h, no scan expected", max_q);
        end else begin
          res_t r;
          r = res_q.pop_front();
          chk("max_q", max_q, r.q);
          chk("max_action", max_action, r.a);
        end
      end else begin
        chk("max_q_hold", max_q, prev_q);
        chk("max_action_hold", max_action, prev_a);
      end
      prev_q = max_q;
      prev_a = max_action;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   c, d0, d1;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst = 1'b1;
    start = 1'b0;
    state_in = '0;

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_max_q", max_q, 0);
    chk("rst_max_action", max_action, 0);
    chk("rst_rd_en", ram_rd_en, 0);
    chk("rst_rd_addr", ram_rd_addr, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    vecs[0] = '{6'd5, 16'd10, 16'd300, 16'hFFF9, 16'd42, 16'd300, 2'd1};
    vecs[1] = '{6'd6, 16'hFFFB, 16'hFFFD, 16'hFFFD, 16'h8000, 16'hFFFD, 2'd1};
    vecs[2] = '{6'd7, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 2'd3};
    vecs[3] = '{6'd8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 2'd0};
    vecs[4] = '{6'd9, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 2'd0};

    for (int v = 0; v < 5; v++) begin
      set_row(vecs[v].st, vecs[v].r0, vecs[v].r1, vecs[v].r2, vecs[v].r3);
      run_scan(vecs[v].st, vecs[v].exp_q, vecs[v].exp_a);
    end

    // Start while busy: only state 1 scanned; start sampled during done ignored, next cycle accepted.
    set_row(6'd1, 16'd100, 16'hFF9C, 16'd50, 16'd99);
    set_row(6'd2, 16'd1000, 16'd2000, 16'd3000, 16'd4000);
    set_row(6'd3, 16'd7, 16'hFFF8, 16'd7, 16'd9);
    @(posedge clk); #1;
    start = 1'b1;
    state_in = 6'd1;
    expect_scan(6'd1, ref_res(6'd1));
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1; state_in = 6'd2;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1; state_in = 6'd2;
    @(negedge clk);
    chk("busy_first_done", done, 1);
    @(posedge clk); #1;
    state_in = 6'd3;
    expect_scan(6'd3, ref_res(6'd3));
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("busy_after_late_start", busy, 1);
    wait_done(c);
    chk("late_start_done_cycle", c, 5);

    // Reset mid-scan: abort, outputs back to zero, then a clean scan of state 63.
    set_row(6'd4, 16'd11, 16'd22, 16'd33, 16'd44);
    @(posedge clk); #1;
    start = 1'b1;
    state_in = 6'd4;
    expect_scan(6'd4, ref_res(6'd4));
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_max_q", max_q, 0);
    chk("abort_max_action", max_action, 0);
    chk("abort_rd_en", ram_rd_en, 0);
    chk("abort_rd_addr", ram_rd_addr, 0);
    res_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    set_row(6'd63, 16'hFFFF, 16'd5, 16'd5, 16'hFFFE);
    run_scan(6'd63, 16'd5, 2'd1);

    // Back-to-back with start held high: done pulses 7 cycles apart.
    set_row(6'd0, 16'd1, 16'd2, 16'd3, 16'd4);
    @(posedge clk); #1;
    start = 1'b1;
    state_in = 6'd0;
    expect_scan(6'd0, ref_res(6'd0));
    @(posedge clk); #1;
    state_in = 6'd1;
    expect_scan(6'd1, ref_res(6'd1));
    d0 = 0;
    d1 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        if (d0 == 0) d0 = k;
        else if (d1 == 0) d1 = k;
      end
      @(posedge clk); #1;
      if (k == 7) start = 1'b0;
    end
    chk("b2b_first_done", d0, 6);
    chk("b2b_second_done", d1, 13);

    repeat (4) @(negedge clk);
    chk("results_pending", res_q.size(), 0);
    chk("reads_pending", addr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
